// File: rtl/frame_writer.sv
// frame_writer: packs an 8-bit pixel stream into 16-bit words and writes whole frames into
// the back framebuffer bank, flipping display_bank on completion. FRAME_WRITER_CLEAR_EN adds back-bank zero-fill.

module frame_writer #(
  parameter int FRAME_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic [14:0] mem_address,
  output logic [15:0] mem_data,
  output logic        busy,
  output logic        frame_done,
  output logic        display_bank
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FLIP  = 3'd3;
`ifdef FRAME_WRITER_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd4;
`endif

  localparam logic [13:0] LAST_IDX = 14'(FRAME_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [13:0] idx_q, idx_d;
  logic        phase_q, phase_d;
  logic        ending_q, ending_d;
  logic [7:0]  hi_q, hi_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        bank_q, bank_d;
  logic        en_q;

`ifndef FRAME_WRITER_CLEAR_EN
  logic unused_clear;
  assign unused_clear = clear;
`endif

  // The first byte of a pair waits in hi_q so mem_data only moves when a word is launched.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    ending_d = ending_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    data_d   = data_q;
    bank_d   = bank_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FILL;
          idx_d    = 14'd0;
          phase_d  = 1'b0;
          ending_d = 1'b0;
        end
`ifdef FRAME_WRITER_CLEAR_EN
        else if (clear) begin
          state_d = S_CLEAR;
          idx_d   = 14'd0;
          addr_d  = {~bank_q, 14'd0};
          data_d  = 16'h0000;
        end
`endif
      end
      S_FILL: begin
        if (in_valid) begin
          if (!phase_q) begin
            if (in_last) begin
              data_d   = {in_data, 8'h00};
              addr_d   = {~bank_q, idx_q};
              ending_d = 1'b1;
              state_d  = S_WRITE;
            end else begin
              hi_d    = in_data;
              phase_d = 1'b1;
            end
          end else begin
            data_d  = {hi_q, in_data};
            addr_d  = {~bank_q, idx_q};
            phase_d = 1'b0;
            if (in_last) begin
              ending_d = 1'b1;
            end
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX || ending_q) begin
          state_d = S_FLIP;
          bank_d  = ~bank_q;
        end else begin
          idx_d   = idx_q + 14'd1;
          state_d = S_FILL;
        end
      end
      S_FLIP: begin
        state_d = S_IDLE;
      end
`ifdef FRAME_WRITER_CLEAR_EN
      // Shares FLIP for the done pulse, but the bank is left alone.
      S_CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FLIP;
        end else begin
          idx_d  = idx_q + 14'd1;
          addr_d = {~bank_q, idx_q + 14'd1};
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 14'd0;
      phase_q  <= 1'b0;
      ending_q <= 1'b0;
      hi_q     <= 8'h00;
      addr_q   <= 15'd0;
      data_q   <= 16'h0000;
      bank_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      ending_q <= ending_d;
      hi_q     <= hi_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      bank_q   <= bank_d;
      en_q     <= 1'b1;
    end
  end

  assign in_ready     = (state_q == S_FILL);
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_FLIP);
  assign mem_enable   = en_q;
  assign mem_address  = addr_q;
  assign mem_data     = data_q;
  assign display_bank = bank_q;

`ifdef FRAME_WRITER_CLEAR_EN
  assign mem_write_enable = (state_q == S_WRITE) || (state_q == S_CLEAR);
`else
  assign mem_write_enable = (state_q == S_WRITE);
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Testbench for frame_writer with FRAME_WORDS=128: vector table for cycle timing,
// randomized frames checked against a byte-pairing reference model.

module tb_frame_writer;

  localparam int FW = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        inValid = 1'b0;
  logic [7:0]  inData = 8'h00;
  logic        inLast = 1'b0;
  logic        inReady;
  logic        memEnable;
  logic        memWriteEnable;
  logic [14:0] memAddress;
  logic [15:0] memData;
  logic        busy;
  logic        frameDone;
  logic        displayBank;

  frame_writer #(.FRAME_WORDS(FW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .clear            (clear),
    .in_valid         (inValid),
    .in_data          (inData),
    .in_last          (inLast),
    .in_ready         (inReady),
    .mem_enable       (memEnable),
    .mem_write_enable (memWriteEnable),
    .mem_address      (memAddress),
    .mem_data         (memData),
    .busy             (busy),
    .frame_done       (frameDone),
    .display_bank     (displayBank)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        st, cl, v, last;
    logic [7:0]  d;
    logic        expReady, expWe, expBusy, expDone, expBank;
    logic [14:0] expAddr;
    logic [15:0] expData;
  } vec_t;

  wr_t        writes[$];
  logic [7:0] frameBytes[$];
  int passed = 0;
  int total = 0;
  int doneCount = 0;
  int doneBefore = 0;
  int cycle = 0;
  int doneCycle = 0;
  int startCycle = 0;
  logic modelBank = 1'b0;

  always @(posedge clk) cycle++;

  // Memory-side observer, sampled shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (memWriteEnable) writes.push_back({memAddress, memData});
    if (frameDone) begin
      doneCount++;
      doneCycle = cycle;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input int gapPct, input bit noisyStart, input bit withLast);
    bit rdy;
    int budget;
    writes.delete();
    doneBefore = doneCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    startCycle = cycle;
    for (int i = 0; i < frameBytes.size(); i++) begin
      while (gapPct > 0 && $urandom_range(99) < gapPct) begin
        inValid = 1'b0;
        inLast = 1'b0;
        start = noisyStart && ($urandom_range(3) == 0);
        @(negedge clk);
        start = 1'b0;
      end
      inValid = 1'b1;
      inData = frameBytes[i];
      inLast = withLast && (i == frameBytes.size() - 1);
      budget = 0;
      do begin
        rdy = inReady;
        @(negedge clk);
        budget++;
      end while (!rdy && budget < 10);
      if (!rdy) begin
        checkOutput("in_ready timeout", rdy, 1);
        break;
      end
    end
    inValid = 1'b0;
    inLast = 1'b0;
  endtask

  task automatic expectFrame(input bit checkRate);
    int n;
    int words;
    int budget;
    logic oldBank;
    logic [15:0] w;
    n = frameBytes.size();
    words = (n + 1) / 2;
    if (words > FW) words = FW;
    oldBank = modelBank;
    budget = 0;
    while (doneCount == doneBefore && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("frame_done pulse", doneCount - doneBefore, 1);
    modelBank = ~oldBank;
    checkOutput("display_bank after flip", displayBank, modelBank);
    if (checkRate) checkOutput("cycles start to done", doneCycle - startCycle, 3 * FW);
    checkOutput("write count", writes.size(), words);
    for (int k = 0; k < words && k < writes.size(); k++) begin
      w[15:8] = frameBytes[2 * k];
      w[7:0] = (2 * k + 1 < n) ? frameBytes[2 * k + 1] : 8'h00;
      checkOutput($sformatf("word %0d addr", k), writes[k].addr, {~oldBank, 14'(k)});
      checkOutput($sformatf("word %0d data", k), writes[k].data, w);
    end
    repeat (2) @(negedge clk);
    checkOutput("busy after frame", busy, 0);
    checkOutput("single flip", doneCount - doneBefore, 1);
  endtask

  initial begin
    vec_t vecs[12];
    bit hit;
    bit adv;
    bit sawBusy;
    int idx;
    logic oldBank;

    #2 rst = 1'b0;
    #2;
    checkOutput("reset in_ready", inReady, 0);
    checkOutput("reset mem_enable", memEnable, 0);
    checkOutput("reset write_enable", memWriteEnable, 0);
    checkOutput("reset address", memAddress, 0);
    checkOutput("reset data", memData, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_done", frameDone, 0);
    checkOutput("reset display_bank", displayBank, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mem_enable after reset", memEnable, 1);

    frameBytes.delete();
    for (int i = 0; i < 2 * FW; i++) frameBytes.push_back(8'(i));
    applyStimulus(0, 1'b0, 1'b0);
    expectFrame(1'b1);

    frameBytes.delete();
    for (int i = 0; i < 2 * FW; i++) frameBytes.push_back(8'($urandom));
    applyStimulus(30, 1'b1, 1'b0);
    expectFrame(1'b0);

    // in_last on the final possible byte behaves like a normal full frame
    frameBytes.delete();
    for (int i = 0; i < 2 * FW; i++) frameBytes.push_back(8'($urandom));
    applyStimulus(0, 1'b0, 1'b1);
    expectFrame(1'b1);

    frameBytes.delete();
    idx = $urandom_range(100, 3);
    for (int i = 0; i < idx; i++) frameBytes.push_back(8'($urandom));
    applyStimulus(20, 1'b1, 1'b1);
    expectFrame(1'b0);

    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    modelBank = 1'b0;
    @(negedge clk);

    vecs[0]  = '{1, 1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 15'h0000, 16'h0000};
    vecs[1]  = '{0, 0, 1, 0, 8'hA1, 1, 0, 1, 0, 0, 15'h0000, 16'h0000};
    vecs[2]  = '{0, 0, 1, 0, 8'hA2, 0, 1, 1, 0, 0, 15'h4000, 16'hA1A2};
    vecs[3]  = '{0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 15'h4000, 16'hA1A2};
    vecs[4]  = '{0, 0, 1, 0, 8'hA3, 1, 0, 1, 0, 0, 15'h4000, 16'hA1A2};
    vecs[5]  = '{1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 15'h4000, 16'hA1A2};
    vecs[6]  = '{0, 0, 1, 0, 8'hA4, 0, 1, 1, 0, 0, 15'h4001, 16'hA3A4};
    vecs[7]  = '{0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 15'h4001, 16'hA3A4};
    vecs[8]  = '{0, 0, 1, 1, 8'hA5, 0, 1, 1, 0, 0, 15'h4002, 16'hA500};
    vecs[9]  = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 1, 15'h4002, 16'hA500};
    vecs[10] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 15'h4002, 16'hA500};
    vecs[11] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 15'h4002, 16'hA500};
    writes.delete();
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].st;
      clear = vecs[i].cl;
      inValid = vecs[i].v;
      inLast = vecs[i].last;
      inData = vecs[i].d;
      @(negedge clk);
      checkOutput($sformatf("vec%0d in_ready", i), inReady, vecs[i].expReady);
      checkOutput($sformatf("vec%0d write_enable", i), memWriteEnable, vecs[i].expWe);
      checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d frame_done", i), frameDone, vecs[i].expDone);
      checkOutput($sformatf("vec%0d display_bank", i), displayBank, vecs[i].expBank);
      checkOutput($sformatf("vec%0d address", i), memAddress, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d data", i), memData, vecs[i].expData);
    end
    start = 1'b0;
    clear = 1'b0;
    inValid = 1'b0;
    inLast = 1'b0;
    checkOutput("odd frame write count", writes.size(), 3);
    modelBank = 1'b1;

    // Asynchronous reset while word 40 is being strobed
    writes.delete();
    oldBank = modelBank;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inValid = 1'b1;
    idx = 0;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      if (memWriteEnable && memAddress[13:0] == 14'd40) hit = 1'b1;
      else begin
        inData = 8'(idx);
        adv = inReady;
        @(negedge clk);
        if (adv) idx++;
      end
    end
    checkOutput("reached word 40 strobe", hit, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid reset write_enable", memWriteEnable, 0);
    checkOutput("mid reset display_bank", displayBank, 0);
    checkOutput("mid reset in_ready", inReady, 0);
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset frame_done", frameDone, 0);
    checkOutput("writes before reset", writes.size(), 41);
    if (writes.size() > 0) begin
      checkOutput("word 40 addr", writes[writes.size() - 1].addr, {~oldBank, 14'd40});
      checkOutput("word 40 data", writes[writes.size() - 1].data, {8'd80, 8'd81});
    end
    inValid = 1'b0;
    modelBank = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    frameBytes.delete();
    frameBytes.push_back(8'h11);
    frameBytes.push_back(8'h22);
    frameBytes.push_back(8'h33);
    applyStimulus(0, 1'b0, 1'b1);
    expectFrame(1'b0);

    writes.delete();
    doneBefore = doneCount;
    oldBank = modelBank;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
`ifdef FRAME_WRITER_CLEAR_EN
    idx = 0;
    while (doneCount == doneBefore && idx < 200) begin
      @(negedge clk);
      idx++;
    end
    checkOutput("clear frame_done", doneCount - doneBefore, 1);
    checkOutput("clear write count", writes.size(), FW);
    for (int k = 0; k < FW && k < writes.size(); k++) begin
      checkOutput($sformatf("clear %0d addr", k), writes[k].addr, {~oldBank, 14'(k)});
      checkOutput($sformatf("clear %0d data", k), writes[k].data, 0);
    end
    repeat (2) @(negedge clk);
    checkOutput("clear display_bank", displayBank, oldBank);
    checkOutput("clear busy after", busy, 0);
`else
    sawBusy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
    end
    checkOutput("clear ignored busy", sawBusy, 0);
    checkOutput("clear ignored writes", writes.size(), 0);
    checkOutput("clear ignored done", doneCount - doneBefore, 0);
    checkOutput("clear ignored bank", displayBank, oldBank);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Write-side counterpart to the VGA painter: accepts an 8-bit pixel stream, packs pairs of pixels into 16-bit words and writes a full frame into the back bank of the double-buffered framebuffer Memory (15-bit address, bit 14 = bank). On frame completion it flips `display_bank`, which drives the painter-side bank select, so the display always scans the last complete frame and never shows tearing.

## Interface
- `FRAME_WORDS`, 16384: words per bank; legal range 2..16384.
- `clk`  input  1  system clock (same clock as Memory).
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle pulse; begins a frame into the back bank.
- `clear`  input  1  one-cycle pulse; zero-fill the back bank (only with `FRAME_WRITER_CLEAR_EN`).
- `in_valid`  input  1  pixel byte valid.
- `in_data`  input  8  pixel byte.
- `in_last`  input  1  qualifies the final byte of a frame.
- `in_ready`  output  1  byte accepted when `in_valid && in_ready`.
- `mem_enable`  output  1  Memory enable.
- `mem_write_enable`  output  1  one-cycle write strobe.
- `mem_address`  output  15  {bank, word index}.
- `mem_data`  output  16  write data.
- `busy`  output  1  high whenever state != IDLE.
- `frame_done`  output  1  one-cycle pulse at frame or clear completion.
- `display_bank`  output  1  bank the painter must read; back bank = `~display_bank`.

## Operation
- States: IDLE, FILL, WRITE, FLIP (CLEAR when the macro is defined).
- IDLE: `in_ready`=0. `start` -> FILL, word index := 0, byte phase := 0. `start` and `clear` in the same cycle: `start` wins. Both are ignored outside IDLE.
- FILL: `in_ready`=1.
  - First accepted byte goes to `mem_data[15:8]`.
  - Second accepted byte goes to `mem_data[7:0]` -> WRITE.
  - `in_last` on a first byte pads `mem_data[7:0]` = 0x00 -> WRITE, and marks the frame ending.
- WRITE: `in_ready`=0. `mem_write_enable`=1 for exactly this cycle; `mem_address` = {~display_bank, index}.
  - If the word index = FRAME_WORDS-1 or the frame is marked ending -> FLIP.
  - Otherwise the index increments and the state returns to FILL.
- FLIP: `display_bank` toggles, `frame_done`=1 for one cycle, then IDLE.
- Frame truncation:
  - A frame with fewer than FRAME_WORDS words (early `in_last`) leaves the remaining back-bank words unmodified.
  - `in_last` asserted on the 2·FRAME_WORDS-th byte has the same effect as its absence.
  - Bytes beyond 2·FRAME_WORDS are never accepted, because the block is back in IDLE by then.
- `mem_enable` is 1 whenever out of reset.
- `mem_address` and `mem_data` hold their values outside WRITE/CLEAR.

## Timing
- Reset values: state IDLE, `display_bank`=0, `in_ready`=0, `mem_enable`=0, `mem_write_enable`=0, `mem_address`=0, `mem_data`=0, `busy`=0, `frame_done`=0. All take effect immediately on the asynchronous assert.
- Reset mid-frame: the write strobe drops immediately and no flip occurs. The partially written back bank stays as written; `display_bank` returns to 0.
- `start` sampled at edge N -> `busy`=1 and `in_ready`=1 from edge N+1.
- Second byte accepted at edge N -> write strobe high during cycle N+1 (edge N+1 to N+2); `in_ready`=1 again from edge N+2.
- Throughput: 2 bytes per 3 cycles under continuous `in_valid`.
- Final write cycle is followed by FLIP: `display_bank` and `frame_done` change at the next edge; `busy`=0 and IDLE one edge later.
- `in_valid` low stalls FILL indefinitely without loss of the held byte.

## Configuration
- `FRAME_WRITER_CLEAR_EN` defined:
  - `clear` in IDLE -> CLEAR state.
  - Writes 0x0000 to indices 0..FRAME_WORDS-1 of the back bank, one word per cycle, with the strobe continuously high.
  - Then pulses `frame_done` and returns to IDLE without toggling `display_bank`.
  - `busy`=1 throughout.
- Not defined: the `clear` port exists but is ignored; the CLEAR state is not built.

## Test plan
- Reset, `start`, stream bytes 0x00..0xFF continuously, FRAME_WORDS=128 -> 128 strobes on bank 1, word k = {2k, 2k+1}; `display_bank`=1 and `frame_done` pulse after the last write; then IDLE.
- Second full frame -> writes go to bank 0, addresses 0x0000..0x007F; `display_bank` returns to 0.
- Odd byte count: 5 bytes A1..A5 with `in_last` on A5 -> 3 writes: A1A2, A3A4, A500; flip; index 3 onward untouched.
- Random `in_valid` gaps and `start` pulses while busy -> data order intact, extra `start` ignored, exactly one flip.
- Async `rst` low during the strobe of word 40 -> strobe drops the same cycle, `display_bank`=0, `in_ready`=0; a subsequent `start` writes bank 1 from index 0.
- With `FRAME_WRITER_CLEAR_EN`, pulse `clear` with FRAME_WORDS=128 -> 128 consecutive zero writes to the back bank, `frame_done` pulse, `display_bank` unchanged. Without the macro -> no strobes and `busy` stays 0.
